// File: rtl/cts_pkg.sv
// Shared types and constants for the time-stamped command scheduler.
package cts_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PRESENT
  } state_t;

  typedef logic [63:0] time_t;

  localparam int DEFAULT_LEAD_TIME = 384;

endpackage

// File: rtl/cts_free_slot.sv
// Lowest-index free slot finder: priority encoder over the inverted valid vector.
module cts_free_slot
  import cts_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Walk from the top down so the lowest free index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_time_scheduler.sv
// Time-stamped command store: accepts commands, purges expired ones and
// presents the earliest pending command LEAD_TIME ticks before it is due.
module cmd_time_scheduler
  import cts_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 274,
  parameter int LEAD_TIME = DEFAULT_LEAD_TIME,
  parameter int CNT_W     = 16
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  time_t                      TIME,
  input  logic                       SYS_TIME_UPDATE,
  input  logic                       flush,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  time_t                      wr_time,
  input  logic [PAYLOAD_W-1:0]       wr_payload,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output time_t                      cmd_time,
  output logic [PAYLOAD_W-1:0]       cmd_payload,
  output logic [$clog2(DEPTH+1)-1:0] free_cnt,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           stale_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int FC_W  = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     slot_valid;
  time_t                slot_time    [DEPTH];
  logic [PAYLOAD_W-1:0] slot_payload [DEPTH];

  state_t           state, state_n;
  logic [IDX_W-1:0] scan_idx, best_idx, free_idx, cand_idx;
  time_t            best_time, cand_time, cur_time;
  logic             best_found, cand_found, free_found;
  logic             cur_valid, cur_stale, cur_better, last, dispatch_ok;
  logic             ste_prev, ste_flag, ste_edge, time_evt, wr_fire, scan_enter;

  cts_free_slot #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_free_slot (
    .valid (slot_valid),
    .idx   (free_idx),
    .found (free_found)
  );

  assign full     = (free_cnt == '0);
  assign empty    = (free_cnt == FC_W'(DEPTH));
  assign wr_ready = (state == IDLE) && !full;
  assign wr_fire  = wr_valid && wr_ready;
  assign ste_edge = SYS_TIME_UPDATE && !ste_prev;
  assign time_evt = ste_edge || ste_flag;

  // Running minimum including the slot under inspection this cycle.
  assign cur_valid   = slot_valid[scan_idx];
  assign cur_time    = slot_time[scan_idx];
  assign cur_stale   = cur_valid && (cur_time < TIME);
  assign cur_better  = cur_valid && !cur_stale && (!best_found || (cur_time < best_time));
  assign cand_found  = best_found || cur_better;
  assign cand_idx    = cur_better ? scan_idx : best_idx;
  assign cand_time   = cur_better ? cur_time : best_time;
  assign last        = (scan_idx == IDX_W'(DEPTH - 1));
  assign dispatch_ok = cand_found && (cand_time <= TIME + time_t'(LEAD_TIME));
  assign scan_enter  = (state_n == SCAN) && (state != SCAN);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (flush)                          state_n = IDLE;
        else if (wr_fire)                   state_n = SCAN;
        else if (time_evt || |slot_valid)   state_n = SCAN;
      end
      SCAN: begin
        if (flush)     state_n = IDLE;
        else if (last) state_n = dispatch_ok ? PRESENT : IDLE;
      end
      PRESENT: begin
        if (flush)                      state_n = IDLE;
        else if (cmd_ready || time_evt) state_n = SCAN;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= SCAN;
      scan_idx    <= '0;
      best_found  <= 1'b0;
      best_idx    <= '0;
      best_time   <= '0;
      slot_valid  <= '0;
      free_cnt    <= FC_W'(DEPTH);
      stale_cnt   <= '0;
      cmd_valid   <= 1'b0;
      cmd_time    <= '0;
      cmd_payload <= '0;
      ste_prev    <= 1'b0;
      ste_flag    <= 1'b0;
    end else begin
      state    <= state_n;
      ste_prev <= SYS_TIME_UPDATE;
      ste_flag <= scan_enter ? 1'b0 : time_evt;
      if (scan_enter) begin
        scan_idx   <= '0;
        best_found <= 1'b0;
      end
      if (flush) begin
        slot_valid <= '0;
        free_cnt   <= FC_W'(DEPTH);
        cmd_valid  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (wr_fire && free_found) begin
              slot_valid[free_idx]   <= 1'b1;
              slot_time[free_idx]    <= wr_time;
              slot_payload[free_idx] <= wr_payload;
              free_cnt               <= free_cnt - FC_W'(1);
            end
          end
          SCAN: begin
            scan_idx   <= scan_idx + IDX_W'(1);
            best_found <= cand_found;
            best_idx   <= cand_idx;
            best_time  <= cand_time;
            if (cur_stale) begin
              slot_valid[scan_idx] <= 1'b0;
              free_cnt             <= free_cnt + FC_W'(1);
              if (stale_cnt != {CNT_W{1'b1}}) stale_cnt <= stale_cnt + CNT_W'(1);
            end
            if (last && dispatch_ok) begin
              cmd_valid   <= 1'b1;
              cmd_time    <= cand_time;
              cmd_payload <= slot_payload[cand_idx];
            end
          end
          PRESENT: begin
            // An accepted handshake takes precedence over a time-reload withdraw.
            if (cmd_ready) begin
              slot_valid[best_idx] <= 1'b0;
              free_cnt             <= free_cnt + FC_W'(1);
              cmd_valid            <= 1'b0;
            end else if (time_evt) begin
              cmd_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  free_cnt_matches_valid: assert property (@(posedge CLK) disable iff (rst)
    free_cnt == FC_W'(DEPTH - $countones(slot_valid)));

endmodule
